spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the SCLK half-period in clk cycles; legal minimum 4.
REQ-002 Parameter CS_SETUP, default 4, SHALL set the clk cycles from cs falling to the first SCLK rising edge; legal minimum 2.
REQ-003 Parameter CS_HOLD, default 2, SHALL set the clk cycles from the last SCLK falling edge to cs rising; legal minimum 1.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request one byte transfer; sampled only when ready=1.
REQ-007 tx_data  in  8  byte to send, latched on accepted start.
REQ-008 rx_data  out  8  last byte received on miso, held until the next done.
REQ-009 done  out  1  one-cycle pulse when rx_data is updated.
REQ-010 ready  out  1  high when a start will be accepted.
REQ-011 sclk  out  1  SPI clock, idle low.
REQ-012 mosi  out  1  serial data out, MSB first.
REQ-013 miso  in  1  serial data in, MSB first; may be high-Z while cs=1.
REQ-014 cs  out  1  active-low chip select.

Function
REQ-015 The protocol SHALL be SPI mode 0: mosi changes only while sclk is low, miso is sampled on the clk cycle in which sclk goes 0->1, MSB first, 8 bits per byte.
REQ-016 States SHALL be IDLE, SETUP, LOW, HIGH and HOLD; ready=1 only in IDLE.
REQ-017 IDLE with start=1: latch tx_data into the shift register, drive cs=0 and mosi=tx_data[7] on the next cycle, load the counter with CS_SETUP, go to SETUP.
REQ-018 SETUP: after CS_SETUP cycles go to LOW, reload the counter with CLK_DIV, bit count 0.
REQ-019 LOW: sclk=0 for CLK_DIV cycles, then go to HIGH, drive sclk=1, and shift miso into the receive register LSB.
REQ-020 HIGH: sclk=1 for CLK_DIV cycles, then drive sclk=0; if bit count<7, shift tx left, increment bit count, go to LOW; if bit count=7, go to HOLD.
REQ-021 HOLD: after CS_HOLD cycles drive cs=1 and mosi=0, copy the receive register to rx_data, pulse done, go to IDLE.
REQ-022 Transfer length, start accepted to done, SHALL be 1+CS_SETUP+16*CLK_DIV+CS_HOLD cycles (71 with defaults).
REQ-023 start while ready=0 SHALL be ignored (non-burst build); tx_data changes after acceptance SHALL NOT affect the byte in flight.
REQ-024 cs SHALL stay high for at least 1 cycle between transfers, so done and the next cs fall are never in the same cycle.
REQ-025 sclk, mosi and cs SHALL be registered outputs with no combinational path from any input.

Reset
REQ-026 Reset SHALL force: state IDLE, sclk=0, mosi=0, cs=1, rx_data=0x00, done=0, ready=1, counters 0.
REQ-027 Reset asserted mid-transfer SHALL abort immediately with no done pulse; rx_data SHALL be 0x00.

Configuration
REQ-028 With SPI_MASTER_BURST_EN defined: start=1 in the last HIGH cycle of bit 7 SHALL latch tx_data, pulse done for the finished byte, keep cs=0, and go to LOW with no SETUP or HOLD; ready SHALL also be 1 in that cycle.
REQ-029 Without SPI_MASTER_BURST_EN: every byte SHALL be a separate cs frame, as in REQ-017 to REQ-021.

Structure
REQ-030 The package spi_pkg SHALL hold the state enum type and the constants SPI_CLK_DIV_MIN=4 and SPI_BITS=8.
REQ-031 One sub-module, spi_sclk_gen, SHALL hold the half-period/setup/hold down-counter and issue a one-cycle expiry pulse; the FSM and shift registers SHALL stay in spi_master.

Verification
REQ-032 Loopback (miso tied to mosi), tx_data=0xA5, defaults: rx_data=0xA5, exactly 8 sclk rising edges, done exactly 71 cycles after start.
REQ-033 Against the team's spi_slave (so_data=0xC3, so_start pulsed while so_ready=1 during SETUP), master tx_data=0x3C: slave si_data=0x3C with si_done, master rx_data=0xC3.
REQ-034 start held high with tx_data changing mid-transfer: exactly one transfer per accepted start, cs high for >=1 cycle between frames, no extra done.
REQ-035 Reset asserted at bit 4 of 0xFF: next cycle cs=1, sclk=0, no done, rx_data=0x00, ready=1.
REQ-036 Burst build, start held for 0x11 then 0x22: cs low continuously, 16 sclk rising edges, two done pulses with rx_data 0x11 then 0x22 (loopback).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master slice.
package spi_pkg;

    localparam int SPI_CLK_DIV_MIN = 4;
    localparam int SPI_BITS        = 8;
    localparam int SPI_CNT_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD
    } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Byte-transfer handshake plus SPI pins, grouped for the master and its user.
interface spi_master_if;

    logic       start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       done;
    logic       ready;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs;

    modport master (
        input  start, tx_data, miso,
        output rx_data, done, ready, sclk, mosi, cs
    );

    modport slave (
        output start, tx_data, miso,
        input  rx_data, done, ready, sclk, mosi, cs
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// Loadable down-counter timing the setup, half-period and hold phases;
// expire is high during the last cycle of a loaded interval.
module spi_sclk_gen
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [SPI_CNT_W-1:0] load_val,
    output logic                 expire
);

    logic [SPI_CNT_W-1:0] count;

    // Loading N yields an interval of exactly N cycles ending in the expiry cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - SPI_CNT_W'(1);
        end
    end

    assign expire = (count == SPI_CNT_W'(1));

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 byte master; define SPI_MASTER_BURST_EN to chain bytes
// back-to-back inside one chip-select frame.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 2
) (
    input logic          clk,
    input logic          reset,
    spi_master_if.master bus
);

    spi_state_t           state, state_n;
    logic                 sclk_q, sclk_n;
    logic                 mosi_q, mosi_n;
    logic                 cs_q, cs_n;
    logic                 done_q, done_n;
    logic [7:0]           rx_data_q, rx_data_n;
    logic [7:0]           tx_sh, tx_sh_n;
    logic [7:0]           rx_sh, rx_sh_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic                 ready_c;
    logic                 cnt_load;
    logic [SPI_CNT_W-1:0] cnt_val;
    logic                 expire;

    spi_sclk_gen u_sclk_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            done_q    <= 1'b0;
            rx_data_q <= 8'h00;
            tx_sh     <= 8'h00;
            rx_sh     <= 8'h00;
            bit_cnt   <= 3'd0;
        end else begin
            state     <= state_n;
            sclk_q    <= sclk_n;
            mosi_q    <= mosi_n;
            cs_q      <= cs_n;
            done_q    <= done_n;
            rx_data_q <= rx_data_n;
            tx_sh     <= tx_sh_n;
            rx_sh     <= rx_sh_n;
            bit_cnt   <= bit_cnt_n;
        end
    end

    // Every pin is registered: the comb block only prepares next values.
    always_comb begin
        state_n   = state;
        sclk_n    = sclk_q;
        mosi_n    = mosi_q;
        cs_n      = cs_q;
        done_n    = 1'b0;
        rx_data_n = rx_data_q;
        tx_sh_n   = tx_sh;
        rx_sh_n   = rx_sh;
        bit_cnt_n = bit_cnt;
        ready_c   = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;

        unique case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    tx_sh_n  = bus.tx_data;
                    mosi_n   = bus.tx_data[7];
                    cs_n     = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = SPI_CNT_W'(CS_SETUP);
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                if (expire) begin
                    cnt_load  = 1'b1;
                    cnt_val   = SPI_CNT_W'(CLK_DIV);
                    bit_cnt_n = 3'd0;
                    state_n   = LOW;
                end
            end
            LOW: begin
                if (expire) begin
                    sclk_n   = 1'b1;
                    rx_sh_n  = {rx_sh[6:0], bus.miso};
                    cnt_load = 1'b1;
                    cnt_val  = SPI_CNT_W'(CLK_DIV);
                    state_n  = HIGH;
                end
            end
            HIGH: begin
                if (expire) begin
                    sclk_n = 1'b0;
                    if (bit_cnt != 3'(SPI_BITS - 1)) begin
                        // Rotating rather than shifting keeps all bits live; only [7] reaches mosi.
                        tx_sh_n   = {tx_sh[6:0], tx_sh[7]};
                        mosi_n    = tx_sh[6];
                        bit_cnt_n = bit_cnt + 3'd1;
                        cnt_load  = 1'b1;
                        cnt_val   = SPI_CNT_W'(CLK_DIV);
                        state_n   = LOW;
                    end else begin
`ifdef SPI_MASTER_BURST_EN
                        ready_c = 1'b1;
                        if (bus.start) begin
                            tx_sh_n   = bus.tx_data;
                            mosi_n    = bus.tx_data[7];
                            rx_data_n = rx_sh;
                            done_n    = 1'b1;
                            bit_cnt_n = 3'd0;
                            cnt_load  = 1'b1;
                            cnt_val   = SPI_CNT_W'(CLK_DIV);
                            state_n   = LOW;
                        end else begin
                            cnt_load = 1'b1;
                            cnt_val  = SPI_CNT_W'(CS_HOLD);
                            state_n  = HOLD;
                        end
`else
                        cnt_load = 1'b1;
                        cnt_val  = SPI_CNT_W'(CS_HOLD);
                        state_n  = HOLD;
`endif
                    end
                end
            end
            HOLD: begin
                if (expire) begin
                    cs_n      = 1'b1;
                    mosi_n    = 1'b0;
                    rx_data_n = rx_sh;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs      = cs_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.ready   = ready_c;

endmodule
